// File: rtl/cronometro_regresivo.sv
// BCD HH:MM:SS countdown timer for the ring-generator clock domain.
// Loads a validated preset, counts down on tick_1hz and holds fin_crono until acknowledged or reloaded.
module cronometro_regresivo #(
  parameter logic [7:0] MAX_HORA = 8'h23
) (
  input  logic       CLK_Ring,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       carga,
  input  logic [7:0] hora_in,
  input  logic [7:0] min_in,
  input  logic [7:0] seg_in,
  input  logic       iniciar,
  input  logic       detener,
  input  logic       apagar_ring,
  output logic [7:0] hora_out,
  output logic [7:0] min_out,
  output logic [7:0] seg_out,
  output logic       fin_crono,
  output logic       corriendo,
  output logic       err_carga
);

  typedef enum logic [1:0] {
    ST_INACTIVO = 2'd0,
    ST_CONTANDO = 2'd1,
    ST_PAUSA    = 2'd2,
    ST_FIN      = 2'd3
  } estado_t;

  estado_t    state_q, state_d;
  logic [7:0] hora_q, hora_d;
  logic [7:0] min_q, min_d;
  logic [7:0] seg_q, seg_d;
  logic       fin_crono_q, fin_crono_d;
  logic       corriendo_q, corriendo_d;
  logic       err_carga_q, err_carga_d;

  logic       carga_ok_s;
  logic       cuenta_cero_s;
  logic       borrow_min_s;
  logic       borrow_hora_s;
  logic [7:0] seg_dec_s;
  logic [7:0] min_dec_s;
  logic [7:0] hora_dec_s;
  logic       dec_cero_s;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic carga_valida(input logic [7:0] h, input logic [7:0] m,
                                        input logic [7:0] s);
    return bcd_ok(h) && bcd_ok(m) && bcd_ok(s) &&
           (m <= 8'h59) && (s <= 8'h59) && (h <= MAX_HORA);
  endfunction

  // Two-digit BCD decrement; 00 wraps to the supplied value (the borrow is handled by the caller).
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = wrap;
    end else if (v[3:0] == 4'h0) begin
      r = {v[7:4] - 4'h1, 4'h9};
    end else begin
      r = {v[7:4], v[3:0] - 4'h1};
    end
    return r;
  endfunction

  // Candidate decremented count and the predicates that drive the FSM.
  always_comb begin
    carga_ok_s    = carga_valida(hora_in, min_in, seg_in);
    cuenta_cero_s = ({hora_q, min_q, seg_q} == 24'h000000);
    borrow_min_s  = (seg_q == 8'h00);
    borrow_hora_s = borrow_min_s && (min_q == 8'h00);
    seg_dec_s     = bcd_dec(seg_q, 8'h59);
    min_dec_s     = borrow_min_s ? bcd_dec(min_q, 8'h59) : min_q;
    hora_dec_s    = borrow_hora_s ? bcd_dec(hora_q, 8'h00) : hora_q;
    dec_cero_s    = ({hora_dec_s, min_dec_s, seg_dec_s} == 24'h000000);
  end

  // Next state, counters and registered flags; a load pre-empts every other command.
  always_comb begin
    state_d     = state_q;
    hora_d      = hora_q;
    min_d       = min_q;
    seg_d       = seg_q;
    err_carga_d = 1'b0;
    if (carga) begin
      if (carga_ok_s) begin
        hora_d  = hora_in;
        min_d   = min_in;
        seg_d   = seg_in;
        state_d = ST_INACTIVO;
      end else begin
        err_carga_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_INACTIVO: begin
          if (iniciar) begin
            state_d = cuenta_cero_s ? ST_FIN : ST_CONTANDO;
          end else begin
            state_d = ST_INACTIVO;
          end
        end
        ST_CONTANDO: begin
          if (detener) begin
            state_d = ST_PAUSA;
          end else if (tick_1hz && !cuenta_cero_s) begin
            hora_d  = hora_dec_s;
            min_d   = min_dec_s;
            seg_d   = seg_dec_s;
            state_d = dec_cero_s ? ST_FIN : ST_CONTANDO;
          end else begin
            state_d = ST_CONTANDO;
          end
        end
        ST_PAUSA: begin
          if (iniciar) begin
            state_d = ST_CONTANDO;
          end else begin
            state_d = ST_PAUSA;
          end
        end
        ST_FIN: begin
          if (apagar_ring) begin
            state_d = ST_INACTIVO;
          end else begin
            state_d = ST_FIN;
          end
        end
        default: begin
          state_d = ST_INACTIVO;
        end
      endcase
    end
    fin_crono_d = (state_d == ST_FIN);
    corriendo_d = (state_d == ST_CONTANDO);
  end

  // State, counters and output flags; asynchronous reset discards the preset.
  always_ff @(posedge CLK_Ring or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INACTIVO;
      hora_q      <= 8'h00;
      min_q       <= 8'h00;
      seg_q       <= 8'h00;
      fin_crono_q <= 1'b0;
      corriendo_q <= 1'b0;
      err_carga_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hora_q      <= hora_d;
      min_q       <= min_d;
      seg_q       <= seg_d;
      fin_crono_q <= fin_crono_d;
      corriendo_q <= corriendo_d;
      err_carga_q <= err_carga_d;
    end
  end

  assign hora_out  = hora_q;
  assign min_out   = min_q;
  assign seg_out   = seg_q;
  assign fin_crono = fin_crono_q;
  assign corriendo = corriendo_q;
  assign err_carga = err_carga_q;

  cronometro_regresivo_chk u_chk (
    .CLK_Ring  (CLK_Ring),
    .reset     (reset),
    .hora_out  (hora_q),
    .min_out   (min_q),
    .seg_out   (seg_q),
    .fin_crono (fin_crono_q),
    .corriendo (corriendo_q)
  );

endmodule

// Invariants on the registered outputs: BCD digits, FIN implies zero, running implies nonzero.
module cronometro_regresivo_chk (
  input logic       CLK_Ring,
  input logic       reset,
  input logic [7:0] hora_out,
  input logic [7:0] min_out,
  input logic [7:0] seg_out,
  input logic       fin_crono,
  input logic       corriendo
);

  logic cero_s;
  assign cero_s = ({hora_out, min_out, seg_out} == 24'h000000);

  a_excl: assert property (@(posedge CLK_Ring) disable iff (reset) !(fin_crono && corriendo));
  a_fin_cero: assert property (@(posedge CLK_Ring) disable iff (reset) fin_crono |-> cero_s);
  a_run_nz: assert property (@(posedge CLK_Ring) disable iff (reset) corriendo |-> !cero_s);
  a_bcd: assert property (@(posedge CLK_Ring) disable iff (reset)
    (seg_out[3:0] <= 4'd9) && (seg_out[7:4] <= 4'd5) &&
    (min_out[3:0] <= 4'd9) && (min_out[7:4] <= 4'd5) &&
    (hora_out[3:0] <= 4'd9) && (hora_out[7:4] <= 4'd9));

endmodule
